// File: rtl/found_tx_scheduler.sv
// Round-robin scheduler that frames one compute unit's result word at a time
// onto a byte-wide RS232 transmitter: header 0x80+unit, then the word MSB first.
module found_tx_scheduler #(
  parameter int NUM_OF_TAPS = 15,
  parameter int NUM_UNITS   = 20
) (
  input  logic                               clk,
  input  logic                               res,
  input  logic [NUM_UNITS-1:0]               found,
  input  logic [NUM_UNITS*NUM_OF_TAPS*8-1:0] co_buf,
  input  logic                               tx_ready,
  output logic [7:0]                         byte_out,
  output logic                               transmit,
  output logic [NUM_UNITS-1:0]               ack,
  output logic                               busy,
  output logic                               overrun
);
  localparam int WW = NUM_OF_TAPS * 8;
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CW = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
  localparam logic [UW:0]   NU        = (UW+1)'(NUM_UNITS);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_OF_TAPS - 1);

  typedef enum logic [2:0] {IDLE, GRANT, HDR, WAIT_H, DATA, WAIT_D} state_t;

  state_t               r_state, w_next;
  logic [NUM_UNITS-1:0] r_pending, r_found_q, w_ack_oh;
  logic [UW-1:0]        r_last_grant, w_winner;
  logic [UW:0]          w_idx;
  logic                 w_hit;
  logic [WW-1:0]        r_buf;
  logic [CW-1:0]        r_byte_cnt;
  logic [7:0]           r_byte_out;
  logic                 r_transmit, r_overrun;
  logic                 w_grant, w_send_hdr, w_send_data;

  // Scan upward from the unit after last_grant, wrapping; first pending wins.
  always_comb begin
    w_winner = r_last_grant;
    w_hit    = 1'b0;
    w_idx    = '0;
    for (int i = 1; i <= NUM_UNITS; i++) begin
      w_idx = {1'b0, r_last_grant} + (UW+1)'(i);
      if (w_idx >= NU) w_idx = w_idx - NU;
      if (!w_hit && r_pending[w_idx[UW-1:0]]) begin
        w_hit    = 1'b1;
        w_winner = w_idx[UW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_send_hdr  = 1'b0;
    w_send_data = 1'b0;
    w_ack_oh    = '0;
    case (r_state)
      IDLE:   if (|r_pending) w_next = GRANT;
      GRANT: begin
        w_grant            = 1'b1;
        w_ack_oh[w_winner] = 1'b1;
        w_next             = HDR;
      end
      HDR: if (tx_ready) begin
        w_send_hdr = 1'b1;
        w_next     = WAIT_H;
      end
      // One dead cycle lets the transmitter drop tx_ready after a load.
      WAIT_H, WAIT_D: w_next = DATA;
      DATA: if (tx_ready) begin
        w_send_data = 1'b1;
        w_next      = (r_byte_cnt == LAST_BYTE) ? IDLE : WAIT_D;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pending    <= '0;
      r_found_q    <= '0;
      r_overrun    <= 1'b0;
      r_last_grant <= UW'(NUM_UNITS - 1);
      r_buf        <= '0;
      r_byte_cnt   <= '0;
      r_byte_out   <= '0;
      r_transmit   <= 1'b0;
    end else begin
      r_found_q  <= found;
      // A new found in the grant cycle wins over the clear.
      r_pending  <= (r_pending & ~w_ack_oh) | found;
      if (|(found & ~r_found_q & r_pending)) r_overrun <= 1'b1;
      r_transmit <= w_send_hdr | w_send_data;
      if (w_grant) begin
        r_last_grant <= w_winner;
        r_buf        <= co_buf[w_winner*WW +: WW];
        r_byte_cnt   <= '0;
      end
      if (w_send_hdr) r_byte_out <= {1'b1, 7'(r_last_grant)};
      // Buffer shifts left so the next byte is always at the top.
      if (w_send_data) begin
        r_byte_out <= r_buf[WW-1 -: 8];
        r_buf      <= r_buf << 8;
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
    end
  end

  assign byte_out = r_byte_out;
  assign transmit = r_transmit;
  assign ack      = w_ack_oh;
  assign busy     = (r_state != IDLE);
  assign overrun  = r_overrun;
endmodule

// File: doc/found_tx_scheduler.md
FOUND_TX_SCHEDULER -- requirements
Module: found_tx_scheduler

Interface
REQ-001 Parameter NUM_OF_TAPS, default 15: bytes per result word; one word is NUM_OF_TAPS*8 bits.
REQ-002 Parameter NUM_UNITS, default 20: number of compute modules (requesters), range 2..64.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 res  input  1: asynchronous, active-high reset.
REQ-005 found  input  NUM_UNITS: per-unit result-ready pulse or level; bit k belongs to unit k.
REQ-006 co_buf  input  NUM_UNITS*NUM_OF_TAPS*8: concatenated result words; unit k occupies bits [(k+1)*NUM_OF_TAPS*8-1 : k*NUM_OF_TAPS*8].
REQ-007 tx_ready  input  1: RS232 transmitter can accept a byte.
REQ-008 byte_out  output  8: byte presented to the transmitter.
REQ-009 transmit  output  1: one-cycle load strobe; byte_out is valid while it is high.
REQ-010 ack  output  NUM_UNITS: one-hot, one-cycle grant acknowledge to the served unit.
REQ-011 busy  output  1: high whenever the state is not IDLE.
REQ-012 overrun  output  1: sticky flag; set when found[k] rises while pending[k] is already set.

Function
REQ-013 The pending register SHALL OR found into pending each cycle; the clear of a granted bit and a new set of that bit in the same cycle SHALL leave the bit set.
REQ-014 The state machine SHALL have states IDLE, GRANT, HDR, WAIT_H, DATA, WAIT_D.
REQ-015 IDLE: if pending is nonzero, go to GRANT on the next edge; otherwise stay in IDLE.
REQ-016 GRANT lasts one cycle:
- Select the round-robin winner: the lowest index above last_grant (wrapping) with pending set.
- Register it as last_grant and snapshot that unit's co_buf word into an internal buffer.
- Clear its pending bit, pulse ack[winner] for exactly this cycle, and go to HDR.
REQ-017 The snapshot SHALL be the only sampling of co_buf; later co_buf changes SHALL NOT affect the frame in progress.
REQ-018 HDR:
- When tx_ready=1, drive byte_out = 8'h80 + winner index (bits [6:0]) and transmit=1 for one cycle, then go to WAIT_H.
- When tx_ready=0, hold.
REQ-019 WAIT_H and WAIT_D SHALL last exactly one cycle with transmit=0, covering the transmitter's tx_ready drop latency, and then go to DATA.
REQ-020 DATA:
- When tx_ready=1, send buffer byte byte_cnt, most significant byte first (byte 0 = bits [NUM_OF_TAPS*8-1 : NUM_OF_TAPS*8-8]), pulse transmit, and increment byte_cnt.
- After the byte with byte_cnt = NUM_OF_TAPS-1, go to IDLE; otherwise go to WAIT_D.
REQ-021 A frame SHALL be 1 + NUM_OF_TAPS bytes; transmit SHALL never be high on two consecutive cycles.
REQ-022 byte_out SHALL hold its last value while transmit=0.
REQ-023 Minimum latency: found[k] high at edge n leads to ack[k] in the cycle after edge n+1 and the header strobe no earlier than edge n+3.
REQ-024 With all units pending, each unit SHALL be served exactly once per NUM_UNITS frames.
REQ-025 last_grant SHALL reset to NUM_UNITS-1, so that unit 0 wins first after reset.

Reset
REQ-026 When res=1, regardless of clk:
- State goes to IDLE; pending, byte_cnt, buffer, byte_out, transmit, ack and overrun clear to 0; busy=0.
REQ-027 A reset asserted mid-frame SHALL abort the frame with no further transmit strobes, and the interrupted unit SHALL NOT be re-served unless found rises again.
REQ-028 The first found sampled after res deasserts SHALL be captured normally.

Verification
REQ-029 Reset, NUM_OF_TAPS=15, tx_ready=1, found=20'h00004 for one cycle with unit 2's word = 0x0102..0F -> ack=20'h00004 for one cycle, then bytes 0x82, 0x01, 0x02 ... 0x0F with transmit strobes two cycles apart, then busy=0.
REQ-030 found=20'hFFFFF held one cycle -> headers 0x80, 0x81 ... 0x93 in order; 20 frames; all pending clear at the end.
REQ-031 tx_ready forced 0 for 50 cycles during DATA -> no transmit strobe and byte_out unchanged; sending resumes in the same byte order when tx_ready returns to 1.
REQ-032 co_buf for the granted unit changed in the cycle after GRANT -> the transmitted bytes match the pre-change snapshot.
REQ-033 res pulsed during byte 7 of a frame -> transmit=0 immediately, busy=0, pending=0, overrun=0; the next found[5] yields header 0x85.
REQ-034 found[3] pulsed twice while unit 3 is pending and not yet granted -> overrun=1 (sticky until reset), and only one unit-3 frame is sent.
